// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide synchronous RAM responder for ICache word fetches and LSU loads/stores.
// Build option MEM_PIPE_READ_EN overlaps read address issue with data capture.
//
// state | meaning
// IDLE  | sample requests (LS over IC), or sit out the post-completion gap
// IC_RD | fetch 4 bytes for the ICache
// LS_RD | load 1/2/4 bytes for the LSU
// LS_WR | store 1/2/4 bytes, one byte per cycle, held off by a full IO buffer
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IC_rn,
  input  logic [31:0] IC_addr,
  output logic        IC_ready,
  output logic [31:0] IC_value,
  input  logic        LS_rn,
  input  logic        LS_wn,
  input  logic [31:0] LS_addr,
  input  logic [1:0]  LS_size,
  input  logic        LS_sext,
  input  logic [31:0] LS_wdata,
  output logic        LS_ready,
  output logic [31:0] LS_value,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IC_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic        io_sel_q, io_sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  skip_q, skip_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        ic_ready_q, ic_ready_d;
  logic [31:0] ic_value_q, ic_value_d;
  logic        ls_ready_q, ls_ready_d;
  logic [31:0] ls_value_q, ls_value_d;

  logic [1:0]  last_idx;
  logic [7:0]  din_b;
  logic        cap_en;
  logic [1:0]  cap_idx;
  logic        rd_last;
  logic        rd_adv;
  logic        wr_last;
  logic        io_stall;
  logic [31:0] cap_word;
  logic [31:0] ls_fmt;
  logic [7:0]  wr_byte;

  always_comb begin
    last_idx = 2'd3;
    case (size_q)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

`ifdef MEM_PIPE_READ_EN
  // The RAM keeps answering while rdy is low, so the byte that was in flight
  // when the freeze began is saved and replayed on the first resumed cycle.
  logic       frz_q;
  logic [7:0] din_sav_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frz_q     <= 1'b0;
      din_sav_q <= 8'h00;
    end else begin
      frz_q <= ~rdy;
      if (!rdy && !frz_q) din_sav_q <= mem_din;
    end
  end

  assign din_b   = frz_q ? din_sav_q : mem_din;
  assign cap_en  = (cnt_q != 3'd0);
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign rd_last = (cnt_q == ({1'b0, last_idx} + 3'd1));
  assign rd_adv  = (cnt_q < {1'b0, last_idx});
`else
  // Two cycles per byte: address in the even cycle, capture in the odd one.
  assign din_b   = mem_din;
  assign cap_en  = cnt_q[0];
  assign cap_idx = cnt_q[2:1];
  assign rd_last = cnt_q[0] && (cnt_q[2:1] == last_idx);
  assign rd_adv  = cnt_q[0];
`endif

  always_comb begin
    cap_word = data_q;
    cap_word[{cap_idx, 3'b000} +: 8] = din_b;
  end

  always_comb begin
    ls_fmt = cap_word;
    case (size_q)
      2'd0:    ls_fmt = {{24{sext_q & cap_word[7]}}, cap_word[7:0]};
      2'd1:    ls_fmt = {{16{sext_q & cap_word[15]}}, cap_word[15:0]};
      default: ls_fmt = cap_word;
    endcase
  end

  assign wr_last  = (cnt_q[1:0] == last_idx);
  assign io_stall = io_sel_q & io_buffer_full;
  assign wr_byte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign mem_wr   = (state_q == LS_WR) & rdy & ~io_stall;
  assign mem_dout = mem_wr ? wr_byte : 8'h00;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    sext_d     = sext_q;
    io_sel_d   = io_sel_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    skip_d     = skip_q;
    mem_a_d    = mem_a_q;
    ic_ready_d = 1'b0;
    ic_value_d = ic_value_q;
    ls_ready_d = 1'b0;
    ls_value_d = ls_value_q;

    case (state_q)
      IDLE: begin
        if (skip_q != 2'd0) begin
          skip_d = skip_q - 2'd1;
        end else if (LS_wn || LS_rn) begin
          state_d  = LS_wn ? LS_WR : LS_RD;
          size_d   = LS_size;
          sext_d   = LS_sext;
          io_sel_d = (LS_addr[17:16] == 2'b11);
          wdata_d  = LS_wdata;
          mem_a_d  = LS_addr;
          cnt_d    = 3'd0;
          data_d   = 32'h0;
        end else if (IC_rn) begin
          state_d  = IC_RD;
          size_d   = 2'd2;
          sext_d   = 1'b0;
          io_sel_d = 1'b0;
          mem_a_d  = IC_addr;
          cnt_d    = 3'd0;
          data_d   = 32'h0;
        end
      end

      IC_RD, LS_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cap_en) data_d = cap_word;
        if (rd_last) begin
          state_d = IDLE;
          skip_d  = 2'd2;
          if (state_q == IC_RD) begin
            ic_ready_d = 1'b1;
            ic_value_d = cap_word;
          end else begin
            ls_ready_d = 1'b1;
            ls_value_d = ls_fmt;
          end
        end else if (rd_adv) begin
          mem_a_d = mem_a_q + 32'd1;
        end
      end

      LS_WR: begin
        if (!io_stall) begin
          if (wr_last) begin
            state_d    = IDLE;
            skip_d     = 2'd2;
            ls_ready_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            mem_a_d = mem_a_q + 32'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      io_sel_q   <= 1'b0;
      wdata_q    <= 32'h0;
      cnt_q      <= 3'd0;
      data_q     <= 32'h0;
      skip_q     <= 2'd0;
      mem_a_q    <= 32'h0;
      ic_ready_q <= 1'b0;
      ic_value_q <= 32'h0;
      ls_ready_q <= 1'b0;
      ls_value_q <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      io_sel_q   <= io_sel_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      skip_q     <= skip_d;
      mem_a_q    <= mem_a_d;
      ic_ready_q <= ic_ready_d;
      ic_value_q <= ic_value_d;
      ls_ready_q <= ls_ready_d;
      ls_value_q <= ls_value_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign IC_ready = ic_ready_q;
  assign IC_value = ic_value_q;
  assign LS_ready = ls_ready_q;
  assign LS_value = ls_value_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table plus hand-written corner sequences; a byte RAM model
// answers the DUT and a scoreboard checks ready pulses, values, timing and writes.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        IC_rn;
  logic [31:0] IC_addr;
  logic        IC_ready;
  logic [31:0] IC_value;
  logic        LS_rn, LS_wn;
  logic [31:0] LS_addr;
  logic [1:0]  LS_size;
  logic        LS_sext;
  logic [31:0] LS_wdata;
  logic        LS_ready;
  logic [31:0] LS_value;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IC_rn(IC_rn), .IC_addr(IC_addr), .IC_ready(IC_ready), .IC_value(IC_value),
    .LS_rn(LS_rn), .LS_wn(LS_wn), .LS_addr(LS_addr), .LS_size(LS_size),
    .LS_sext(LS_sext), .LS_wdata(LS_wdata), .LS_ready(LS_ready), .LS_value(LS_value),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  localparam int OP_IC = 0;
  localparam int OP_LD = 1;
  localparam int OP_ST = 2;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic        chk;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;

  rsp_t ic_q[$];
  rsp_t ls_q[$];
  wr_t  wr_q[$];
  rsp_t ic_e, ls_e;
  wr_t  wr_e;
  vec_t vecs[18];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ic_seen = 0;
  int ls_seen = 0;
  int dout_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: read data appears one cycle after the address.
  logic [7:0] ram [0:262143];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
      ram[18'h01000] <= 8'h13; ram[18'h01001] <= 8'h05;
      ram[18'h01002] <= 8'h00; ram[18'h01003] <= 8'h00;
      ram[18'h01004] <= 8'h93; ram[18'h01005] <= 8'h00;
      ram[18'h01006] <= 8'h10; ram[18'h01007] <= 8'h00;
      ram[18'h02000] <= 8'h11; ram[18'h02001] <= 8'h22;
      ram[18'h02002] <= 8'hF3; ram[18'h02003] <= 8'h80;
      ram[18'h02004] <= 8'h7F; ram[18'h02005] <= 8'hFE;
      ram_init <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[17:0]];
  end

  function automatic int rd_lat(input int n);
`ifdef MEM_PIPE_READ_EN
    return n + 2;
`else
    return 2 * n + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (IC_ready) begin
      ic_seen++;
      tests++;
      if (ic_q.size() == 0) begin
        fails++;
        $display("FAIL ic_rsp unexpected pulse at cycle %0d value %h, required none", cyc, IC_value);
      end else begin
        ic_e = ic_q.pop_front();
        if (IC_value !== ic_e.val || cyc != ic_e.cyc) begin
          fails++;
          $display("FAIL ic_rsp: got %h at cycle %0d, required %h at cycle %0d", IC_value, cyc, ic_e.val, ic_e.cyc);
        end
      end
    end
    if (LS_ready) begin
      ls_seen++;
      tests++;
      if (ls_q.size() == 0) begin
        fails++;
        $display("FAIL ls_rsp unexpected pulse at cycle %0d value %h, required none", cyc, LS_value);
      end else begin
        ls_e = ls_q.pop_front();
        if ((ls_e.chk && LS_value !== ls_e.val) || cyc != ls_e.cyc) begin
          fails++;
          $display("FAIL ls_rsp: got %h at cycle %0d, required %h at cycle %0d", LS_value, cyc, ls_e.val, ls_e.cyc);
        end
      end
    end
    if (mem_wr) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL wr unexpected write %h@%h at cycle %0d, required none", mem_dout, mem_a, cyc);
      end else begin
        wr_e = wr_q.pop_front();
        if (mem_a !== wr_e.a || mem_dout !== wr_e.d || cyc != wr_e.cyc) begin
          fails++;
          $display("FAIL wr: got %h@%h cycle %0d, required %h@%h cycle %0d", mem_dout, mem_a, cyc, wr_e.d, wr_e.a, wr_e.cyc);
        end
      end
    end else if (mem_dout !== 8'h00) begin
      dout_bad++;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input logic is_ic, input int seen0, input string name);
    int t;
    t = 0;
    while (((is_ic ? ic_seen : ls_seen) == seen0) && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 60) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no ready pulse in 60 cycles, required one", name);
    end
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    IC_rn = 1'b0; LS_rn = 1'b0; LS_wn = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int c0, n, seen0;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    @(posedge clk); #1;
    c0 = cyc;
    if (v.op == OP_IC) begin
      seen0 = ic_seen;
      IC_rn = 1'b1; IC_addr = v.addr;
      ic_q.push_back(rsp_t'{v.exp, 1'b1, c0 + rd_lat(4)});
    end else begin
      seen0 = ls_seen;
      LS_addr = v.addr; LS_size = v.size; LS_sext = v.sext; LS_wdata = v.wdata;
      if (v.op == OP_ST) begin
        LS_wn = 1'b1;
        ls_q.push_back(rsp_t'{32'h0, 1'b0, c0 + n + 1});
        for (int k = 0; k < n; k++)
          wr_q.push_back(wr_t'{v.addr + k, v.wdata[8*k +: 8], c0 + 1 + k});
      end else begin
        LS_rn = 1'b1;
        ls_q.push_back(rsp_t'{v.exp, 1'b1, c0 + rd_lat(n)});
      end
    end
    wait_done(v.op == OP_IC, seen0, "vec");
    drop_reqs();
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_ic_ready"}, {31'h0, IC_ready}, 32'h0);
    check32({tag, "_ic_value"}, IC_value, 32'h0);
    check32({tag, "_ls_ready"}, {31'h0, LS_ready}, 32'h0);
    check32({tag, "_ls_value"}, LS_value, 32'h0);
    check32({tag, "_mem_a"}, mem_a, 32'h0);
    check32({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
    check32({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, si, sl;
    vecs[0]  = '{OP_IC, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 32'h0000_0513};
    vecs[1]  = '{OP_IC, 32'h0000_1004, 2'd2, 1'b0, 32'h0, 32'h0010_0093};
    vecs[2]  = '{OP_LD, 32'h0000_2003, 2'd0, 1'b1, 32'h0, 32'hFFFF_FF80};
    vecs[3]  = '{OP_LD, 32'h0000_2003, 2'd0, 1'b0, 32'h0, 32'h0000_0080};
    vecs[4]  = '{OP_LD, 32'h0000_2000, 2'd0, 1'b1, 32'h0, 32'h0000_0011};
    vecs[5]  = '{OP_LD, 32'h0000_2002, 2'd1, 1'b1, 32'h0, 32'hFFFF_80F3};
    vecs[6]  = '{OP_LD, 32'h0000_2002, 2'd1, 1'b0, 32'h0, 32'h0000_80F3};
    vecs[7]  = '{OP_LD, 32'h0000_2000, 2'd2, 1'b1, 32'h0, 32'h80F3_2211};
    vecs[8]  = '{OP_LD, 32'h0000_2000, 2'd3, 1'b1, 32'h0, 32'h80F3_2211};
    vecs[9]  = '{OP_ST, 32'h0000_0200, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0};
    vecs[10] = '{OP_LD, 32'h0000_0200, 2'd1, 1'b1, 32'h0, 32'hFFFF_BEEF};
    vecs[11] = '{OP_LD, 32'h0000_0202, 2'd0, 1'b0, 32'h0, 32'h0000_0000};
    vecs[12] = '{OP_ST, 32'h0000_0300, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0};
    vecs[13] = '{OP_LD, 32'h0000_0300, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D};
    vecs[14] = '{OP_ST, 32'h0000_0302, 2'd0, 1'b0, 32'h0000_0077, 32'h0};
    vecs[15] = '{OP_LD, 32'h0000_0300, 2'd2, 1'b0, 32'h0, 32'hCA77_F00D};
    vecs[16] = '{OP_LD, 32'h0000_2004, 2'd1, 1'b1, 32'h0, 32'hFFFF_FE7F};
    vecs[17] = '{OP_LD, 32'h0000_2001, 2'd1, 1'b0, 32'h0, 32'h0000_F322};

    rst = 1'b1; rdy = 1'b1; IC_rn = 1'b0; IC_addr = 32'h0;
    LS_rn = 1'b0; LS_wn = 1'b0; LS_addr = 32'h0; LS_size = 2'd0;
    LS_sext = 1'b0; LS_wdata = 32'h0; io_buffer_full = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // LS and IC requested together: LS first, IC two cycles after LS_ready.
    @(posedge clk); #1;
    c0 = cyc; sl = ls_seen; si = ic_seen;
    LS_rn = 1'b1; LS_addr = 32'h2003; LS_size = 2'd0; LS_sext = 1'b1;
    IC_rn = 1'b1; IC_addr = 32'h1000;
    ls_q.push_back(rsp_t'{32'hFFFF_FF80, 1'b1, c0 + rd_lat(1)});
    ic_q.push_back(rsp_t'{32'h0000_0513, 1'b1, c0 + rd_lat(1) + 2 + rd_lat(4)});
    wait_done(1'b0, sl, "prio_ls");
    @(posedge clk); #1;
    LS_rn = 1'b0;
    wait_done(1'b1, si, "prio_ic");
    drop_reqs();

    // IC_rn held; address moves to 0x1004 on the ready edge.
    @(posedge clk); #1;
    c0 = cyc; si = ic_seen;
    IC_rn = 1'b1; IC_addr = 32'h1000;
    ic_q.push_back(rsp_t'{32'h0000_0513, 1'b1, c0 + rd_lat(4)});
    ic_q.push_back(rsp_t'{32'h0010_0093, 1'b1, c0 + 2 * rd_lat(4) + 2});
    wait_done(1'b1, si, "held_ic1");
    @(posedge clk); #1;
    IC_addr = 32'h1004;
    wait_done(1'b1, si + 1, "held_ic2");
    drop_reqs();

    // Byte store to IO space with a full buffer through C0..C2.
    @(posedge clk); #1;
    c0 = cyc; sl = ls_seen;
    LS_wn = 1'b1; LS_addr = 32'h3_0000; LS_size = 2'd0; LS_wdata = 32'h0000_005A;
    io_buffer_full = 1'b1;
    wr_q.push_back(wr_t'{32'h3_0000, 8'h5A, c0 + 3});
    ls_q.push_back(rsp_t'{32'h0, 1'b0, c0 + 4});
    repeat (3) @(posedge clk); #1;
    io_buffer_full = 1'b0;
    wait_done(1'b0, sl, "io_stall");
    drop_reqs();

    // Non-IO address is not held off by a full IO buffer.
    @(posedge clk); #1;
    c0 = cyc; sl = ls_seen;
    LS_wn = 1'b1; LS_addr = 32'h2_0000; LS_size = 2'd0; LS_wdata = 32'h0000_00A5;
    io_buffer_full = 1'b1;
    wr_q.push_back(wr_t'{32'h2_0000, 8'hA5, c0 + 1});
    ls_q.push_back(rsp_t'{32'h0, 1'b0, c0 + 2});
    wait_done(1'b0, sl, "no_io_stall");
    io_buffer_full = 1'b0;
    drop_reqs();

    // rdy low for one cycle inside a word store.
    @(posedge clk); #1;
    c0 = cyc; sl = ls_seen;
    LS_wn = 1'b1; LS_addr = 32'h400; LS_size = 2'd2; LS_wdata = 32'h4433_2211;
    wr_q.push_back(wr_t'{32'h400, 8'h11, c0 + 1});
    wr_q.push_back(wr_t'{32'h401, 8'h22, c0 + 3});
    wr_q.push_back(wr_t'{32'h402, 8'h33, c0 + 4});
    wr_q.push_back(wr_t'{32'h403, 8'h44, c0 + 5});
    ls_q.push_back(rsp_t'{32'h0, 1'b0, c0 + 6});
    repeat (2) @(posedge clk); #1;
    rdy = 1'b0;
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(1'b0, sl, "rdy_wr");
    drop_reqs();

    // rdy low in C3 and C4 of an IC fetch delays IC_ready by two.
    @(posedge clk); #1;
    c0 = cyc; si = ic_seen;
    IC_rn = 1'b1; IC_addr = 32'h1000;
    ic_q.push_back(rsp_t'{32'h0000_0513, 1'b1, c0 + rd_lat(4) + 2});
    repeat (3) @(posedge clk); #1;
    rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(1'b1, si, "rdy_ic");
    drop_reqs();

    // Reset in C3 of an IC fetch: outputs clear, no IC_ready ever follows.
    @(posedge clk); #1;
    c0 = cyc; si = ic_seen;
    IC_rn = 1'b1; IC_addr = 32'h1004;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1; IC_rn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    repeat (15) @(negedge clk);
    check32("midrst_no_ready", ic_seen, si);

    check32("ic_pending_left", 32'(ic_q.size()), 32'h0);
    check32("ls_pending_left", 32'(ls_q.size()), 32'h0);
    check32("wr_pending_left", 32'(wr_q.size()), 32'h0);
    check32("dout_idle_nonzero", dout_bad, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
